ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 35 +++
 rtl/ifetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// ============================================================================
// Module      : ifetch_unit_if
// Description : Instruction-side request/response bus between the fetch unit
//               (master) and the instruction memory interconnect (slave).
//               Requests use inst_req/inst_addr/inst_addr_ok; responses come
//               back in order on inst_data_ok/inst_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage. Holds the fetch PC, issues at most one
//               outstanding instruction request, buffers a returned word while
//               decode is stalled, drops responses made stale by a redirect,
//               and registers the fetch-to-decode bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit (
  input  wire logic        clk,
  input  wire logic        rst,

  // instruction memory bus
  ifetch_unit_if.master    bus,

  // control from decode / hazard unit
  input  wire logic [31:0] f_nextpc,
  input  wire logic        f_indelayslot,
  input  wire logic        flush,
  input  wire logic        stall_d,

  // current fetch PC
  output logic      [31:0] f_nowpc,
  output logic      [31:0] f_pcplus4,

  // registered fetch-to-decode bundle
  output logic      [31:0] ftod_pc,
  output logic      [31:0] ftod_pcplus4,
  output logic      [31:0] ftod_instr,
  output logic             ftod_in_delay_slot,
  output logic             ftod_addr_err_if,
  output logic             ftod_is_instr,
  output logic             ftod_valid,

  output logic             f_busy
);

  localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

  // REQ     : ready to issue a request for pc (or deliver a misaligned fault)
  // WAIT    : request accepted, waiting for its data
  // HOLD    : data arrived while decode was stalled, word kept in r_buf
  // DISCARD : a redirect made the outstanding response stale; swallow it
  localparam logic [1:0] c_ST_REQ     = 2'd0;
  localparam logic [1:0] c_ST_WAIT    = 2'd1;
  localparam logic [1:0] c_ST_HOLD    = 2'd2;
  localparam logic [1:0] c_ST_DISCARD = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_buf;

  logic        w_misaligned;
  logic        w_inst_req;
  logic        w_avail;
  logic [31:0] w_instr;
  logic        w_fire;
  logic        w_buf_load;
  logic [31:0] w_pcplus4;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_pcplus4    = r_pc + 32'd4;

  // An instruction is consumed only when decode can take it and no redirect
  // is pending in the same cycle.
  assign w_fire     = w_avail & ~stall_d & ~flush;
  // Data that arrives while decode is stalled is parked so the bus is free.
  assign w_buf_load = (r_state == c_ST_WAIT) & bus.inst_data_ok & stall_d & ~flush;

  assign bus.inst_req  = w_inst_req;
  assign bus.inst_addr = r_pc;

  assign f_nowpc   = r_pc;
  assign f_pcplus4 = w_pcplus4;
  assign f_busy    = ~w_avail;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a redirect always wins over stall and fire
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_REQ: begin
        if (flush) begin
          // a request accepted in the redirect cycle is now stale
          w_state_nxt = (w_inst_req & bus.inst_addr_ok) ? c_ST_DISCARD : c_ST_REQ;
        end else if (w_inst_req & bus.inst_addr_ok) begin
          w_state_nxt = c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (flush) begin
          w_state_nxt = bus.inst_data_ok ? c_ST_REQ : c_ST_DISCARD;
        end else if (bus.inst_data_ok) begin
          w_state_nxt = stall_d ? c_ST_HOLD : c_ST_REQ;
        end
      end
      c_ST_HOLD: begin
        if (flush | w_fire) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      c_ST_DISCARD: begin
        if (bus.inst_data_ok) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      default: begin
        w_state_nxt = c_ST_REQ;
      end
    endcase
  end

  // FSM outputs: request strobe, availability and the instruction word source
  always_comb begin
    w_inst_req = 1'b0;
    w_avail    = 1'b0;
    w_instr    = 32'h0;
    case (r_state)
      c_ST_REQ: begin
        // a misaligned pc never reaches memory; it becomes a fault at once
        w_inst_req = ~w_misaligned;
        w_avail    = w_misaligned;
        w_instr    = 32'h0;
      end
      c_ST_WAIT: begin
        w_avail = bus.inst_data_ok;
        w_instr = bus.inst_rdata;
      end
      c_ST_HOLD: begin
        w_avail = 1'b1;
        w_instr = r_buf;
      end
      default: begin
        w_inst_req = 1'b0;
      end
    endcase
  end

  // Fetch PC: advances on delivery, jumps on redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= c_RESET_PC;
    end else if (flush | w_fire) begin
      r_pc <= f_nextpc;
    end
  end

  // Holding buffer for a word returned while decode was stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= 32'h0;
    end else if (w_buf_load) begin
      r_buf <= bus.inst_rdata;
    end
  end

  // Fetch-to-decode bundle: load on fire, hold on stall, bubble otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftod_pc            <= 32'h0;
      ftod_pcplus4       <= 32'h0;
      ftod_instr         <= 32'h0;
      ftod_in_delay_slot <= 1'b0;
      ftod_addr_err_if   <= 1'b0;
      ftod_is_instr      <= 1'b0;
      ftod_valid         <= 1'b0;
    end else if (flush) begin
      ftod_is_instr <= 1'b0;
      ftod_valid    <= 1'b0;
    end else if (w_fire) begin
      ftod_pc            <= r_pc;
      ftod_pcplus4       <= w_pcplus4;
      ftod_instr         <= w_instr;
      ftod_in_delay_slot <= f_indelayslot;
      ftod_addr_err_if   <= w_misaligned;
      ftod_is_instr      <= 1'b1;
      ftod_valid         <= 1'b1;
    end else if (~stall_d) begin
      ftod_is_instr <= 1'b0;
      ftod_valid    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Randomized self-checking bench for ifetch_unit. A small
//               in-order memory responder drives the bus; a transaction-level
//               reference model (pc, outstanding request, held word) predicts
//               the request strobe, busy flag and the decode bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;
  localparam int          c_CYCLES   = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_nextpc = 32'h0;
  logic        f_indelayslot = 1'b0;
  logic        flush = 1'b0;
  logic        stall_d = 1'b0;
  logic [31:0] f_nowpc, f_pcplus4;
  logic [31:0] ftod_pc, ftod_pcplus4, ftod_instr;
  logic        ftod_in_delay_slot, ftod_addr_err_if, ftod_is_instr, ftod_valid;
  logic        f_busy;

  ifetch_unit_if bus ();

  ifetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .f_nextpc           (f_nextpc),
    .f_indelayslot      (f_indelayslot),
    .flush              (flush),
    .stall_d            (stall_d),
    .f_nowpc            (f_nowpc),
    .f_pcplus4          (f_pcplus4),
    .ftod_pc            (ftod_pc),
    .ftod_pcplus4       (ftod_pcplus4),
    .ftod_instr         (ftod_instr),
    .ftod_in_delay_slot (ftod_in_delay_slot),
    .ftod_addr_err_if   (ftod_addr_err_if),
    .ftod_is_instr      (ftod_is_instr),
    .ftod_valid         (ftod_valid),
    .f_busy             (f_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: transaction-level view of the fetch stage
  logic [31:0] m_pc;
  logic        m_out;       // a request is outstanding at the memory
  logic        m_wanted;    // its response is still wanted
  logic        m_held;      // a returned word waits for decode
  logic [31:0] m_held_word;
  logic        e_valid, e_isinstr, e_ds, e_err;
  logic [31:0] e_pc, e_pcp4, e_instr;

  // memory responder: addresses of accepted requests, oldest first
  logic [31:0] s_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = c_RESET_PC; m_out = 1'b0; m_wanted = 1'b0; m_held = 1'b0; m_held_word = 32'h0;
    e_valid = 1'b0; e_isinstr = 1'b0; e_ds = 1'b0; e_err = 1'b0;
    e_pc = 32'h0; e_pcp4 = 32'h0; e_instr = 32'h0;
    s_q.delete();
  endtask

  // asynchronous reset, checked before any clock edge sees it
  task automatic do_reset();
    flush = 1'b0; stall_d = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
    rst = 1'b1;
    #1;
    chk("rst_nowpc",  f_nowpc, c_RESET_PC);
    chk("rst_pcp4",   f_pcplus4, c_RESET_PC + 32'd4);
    chk("rst_valid",  32'(ftod_valid), 32'd0);
    chk("rst_isinstr", 32'(ftod_is_instr), 32'd0);
    chk("rst_ftodpc", ftod_pc, 32'h0);
    chk("rst_instr",  ftod_instr, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        al, req, hs, dok, av, fi;
    logic [31:0] wd, tmp;
    int          stall_pct;

    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
      stall_pct = (cyc < c_CYCLES / 2) ? 20 : 60;

      // occasional reset in the middle of traffic
      if (cyc > 50 && $urandom_range(0, 199) == 0) begin
        do_reset();
      end

      // drive stimulus for this cycle
      stall_d       = ($urandom_range(0, 99) < stall_pct);
      flush         = ($urandom_range(0, 99) < 8);
      f_indelayslot = $urandom_range(0, 1) == 1;
      tmp = $urandom;
      case ($urandom_range(0, 9))
        0: begin tmp[1:0] = 2'($urandom_range(1, 3)); f_nextpc = tmp; end
        1: f_nextpc = 32'hFFFF_FFFC;
        default: begin tmp[1:0] = 2'b00; f_nextpc = tmp; end
      endcase
      bus.inst_addr_ok = ($urandom_range(0, 2) != 0);
      if (s_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(s_q[0]);
      end else begin
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = $urandom;
      end
      #1;

      // predictions for this cycle
      al  = (m_pc[1:0] == 2'b00);
      req = !m_out && !m_held && al;
      hs  = req && bus.inst_addr_ok;
      dok = m_out && bus.inst_data_ok;
      av  = (dok && m_wanted) || m_held || (!m_out && !al);
      wd  = m_held ? m_held_word : (dok ? bus.inst_rdata : 32'h0);
      fi  = av && !stall_d && !flush;

      chk("inst_req", 32'(bus.inst_req), 32'(req));
      if (req) chk("inst_addr", bus.inst_addr, m_pc);
      chk("f_nowpc", f_nowpc, m_pc);
      chk("f_pcplus4", f_pcplus4, m_pc + 32'd4);
      chk("f_busy", 32'(f_busy), 32'(!av));

      // memory responder bookkeeping
      if (dok) void'(s_q.pop_front());
      if (hs) s_q.push_back(m_pc);

      // advance the model by one clock
      if (flush) begin
        m_pc = f_nextpc; e_valid = 1'b0; e_isinstr = 1'b0; m_held = 1'b0;
        if (dok) m_out = 1'b0;
        else if (m_out) m_wanted = 1'b0;
        else if (hs) begin m_out = 1'b1; m_wanted = 1'b0; end
      end else begin
        if (fi) begin
          e_valid = 1'b1; e_isinstr = 1'b1;
          e_pc = m_pc; e_pcp4 = m_pc + 32'd4; e_instr = wd;
          e_ds = f_indelayslot; e_err = !al;
          m_pc = f_nextpc; m_held = 1'b0;
        end else if (av && stall_d && dok) begin
          m_held = 1'b1; m_held_word = bus.inst_rdata;
        end
        if (!fi && !stall_d) begin e_valid = 1'b0; e_isinstr = 1'b0; end
        if (dok) m_out = 1'b0;
        if (hs) begin m_out = 1'b1; m_wanted = 1'b1; end
      end

      @(posedge clk);
      #1;
      chk("ftod_valid", 32'(ftod_valid), 32'(e_valid));
      chk("ftod_is_instr", 32'(ftod_is_instr), 32'(e_isinstr));
      if (e_valid) begin
        chk("ftod_pc", ftod_pc, e_pc);
        chk("ftod_pcplus4", ftod_pcplus4, e_pcp4);
        chk("ftod_instr", ftod_instr, e_instr);
        chk("ftod_ds", 32'(ftod_in_delay_slot), 32'(e_ds));
        chk("ftod_err", 32'(ftod_addr_err_if), 32'(e_err));
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
